fusion_out_tx: RTL and testbench
================================

Name: fusion_out_tx

Overview:
- Output-side transmitter for the fusion datapath. Consumes the Kalman estimate stream (`kalman_data`/`kalman_valid`) produced by `fusion_top`.
- Buffers samples in a small FIFO, because `fusion_top` has no backpressure.
- Serialises each sample into a 5-byte framed packet on an 8-bit valid/ready byte stream toward the host link.
- Counts samples lost to overflow.

Parameters:
- FIFO_DEPTH, 8, sample FIFO entries; must be a power of two, ≥2.
- SYNC_BYTE, 8'hA5, first byte of every frame.
- DATA_WIDTH, 16, sample width; fixed at 16, since the frame carries exactly two data bytes.

Ports:
- clk  in  1  single system clock, all logic rising-edge.
- rst_n  in  1  synchronous, active-low reset.
- kalman_data  in  16  fused estimate from fusion_top.
- kalman_valid  in  1  one-cycle strobe; sample is written when high.
- tx_data  out  8  current frame byte.
- tx_valid  out  1  tx_data valid.
- tx_ready  in  1  downstream accepts the byte when tx_valid && tx_ready.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  entries currently in the FIFO.
- drop_cnt  out  16  samples dropped on overflow; saturates at 16'hFFFF.
- busy  out  1  high whenever the FSM is not IDLE.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - Outputs: tx_valid=0, tx_data=8'h00, fifo_level=0, drop_cnt=0, busy=0.
  - Internal: seq=8'h00, FIFO emptied, FSM=IDLE.
  - Reset mid-frame aborts the frame with no completion bytes. tx_valid is low from the cycle after the reset edge.
- Frame format, in order: SYNC_BYTE, SEQ, DATA_HI=data[15:8], DATA_LO=data[7:0], CSUM.
  - CSUM = SEQ ^ DATA_HI ^ DATA_LO.
- Sequence number:
  - SEQ increments by 1 after each completed CSUM handshake.
  - Wraps 8'hFF→8'h00.
  - Dropped samples do not consume a sequence number.
- FIFO write: when kalman_valid=1.
  - Not full: write.
  - Full with a pop in the same cycle: write (level unchanged).
  - Full with no pop: drop the sample and increment drop_cnt (saturating).
- FIFO pop: loads a 16-bit holding register.
  - Occurs in IDLE when the FIFO is non-empty.
  - Also occurs in the cycle of the CSUM handshake when the FIFO is non-empty, giving back-to-back frames with no idle bubble.
- FSM states: IDLE → SYNC → SEQ → HI → LO → CSUM.
  - IDLE: tx_valid=0. If the FIFO is non-empty, pop and go to SYNC.
  - SYNC, SEQ, HI, LO: tx_valid=1 with the corresponding byte; advance only on tx_valid && tx_ready.
  - CSUM: on handshake, go to SYNC if the FIFO is non-empty (with pop), else to IDLE.
- Handshake rules:
  - tx_data and tx_valid are registered.
  - While tx_valid && !tx_ready, tx_data is held stable and tx_valid stays high.
  - tx_valid never drops mid-frame except on reset.
- Latency: a sample strobed in cycle N into an empty FIFO with the FSM in IDLE is popped at the end of N+1. SYNC appears with tx_valid=1 in cycle N+2.
- Throughput: with tx_ready=1 continuously, one frame per 5 cycles.
- Effective buffering: FIFO_DEPTH samples plus one in the holding register.
- fifo_level: reflects the post-edge occupancy (registered).

Test Plan:
- Single sample: kalman_data=16'h1234 strobed in cycle N, tx_ready=1.
  - Response: bytes A5,00,12,34,26 on cycles N+2..N+6.
  - tx_valid low at N+7; busy low after the CSUM handshake.
- Back-to-back: samples 16'h0001, 16'h0002, 16'h0003 on consecutive cycles, tx_ready=1.
  - Response: 15 consecutive valid cycles, SEQ 00,01,02.
  - CSUMs 01,03,01; no idle gap between frames.
- Backpressure: tx_ready=0 for 3 cycles while DATA_HI=8'h12 is presented.
  - Response: tx_data holds 8'h12 and tx_valid stays 1 for all 3 cycles.
  - Frame then completes correctly.
- Overflow: tx_ready=0, 10 samples strobed on consecutive cycles, FIFO_DEPTH=8.
  - Response: 9 samples accepted (1 in the holding register, 8 in the FIFO), fifo_level=8, drop_cnt=1.
  - After releasing tx_ready, exactly 9 frames are sent with SEQ 00..08.
- Sequence wrap: 257 samples sent, 16'h00FF each.
  - Response: frame 256 has SEQ=FF, CSUM=FF^00^FF=00.
  - Frame 257 has SEQ=00, CSUM=FF.
- Reset mid-frame: assert rst_n=0 for 1 cycle during the HI byte, with 3 samples queued.
  - Response: tx_valid=0, fifo_level=0, drop_cnt=0 the next cycle.
  - A new sample afterward produces a frame with SEQ=00.

Source files
------------

// File: rtl/fusion_out_tx.sv
// Output-side transmitter: buffers Kalman estimates in a small FIFO and sends each
// one as a 5-byte framed packet (SYNC, SEQ, HI, LO, CSUM) on a valid/ready byte stream.
module fusion_out_tx #(
  parameter int          FIFO_DEPTH = 8,
  parameter logic [7:0]  SYNC_BYTE  = 8'hA5,
  parameter int          DATA_WIDTH = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [DATA_WIDTH-1:0]         kalman_data,
  input  logic                          kalman_valid,
  output logic [7:0]                    tx_data,
  output logic                          tx_valid,
  input  logic                          tx_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [15:0]                   drop_cnt,
  output logic                          busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   LVL_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   LVL_FULL = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    ST_IDLE, ST_SYNC, ST_SEQ, ST_HI, ST_LO, ST_CSUM
  } state_t;

  logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]         r_wr_ptr;
  logic [AW-1:0]         r_rd_ptr;
  logic [AW:0]           r_level;
  logic [15:0]           r_drop_cnt;
  logic [DATA_WIDTH-1:0] r_hold;
  logic [7:0]            r_seq;
  logic [7:0]            r_tx_data;
  logic                  r_tx_valid;
  state_t                r_state;

  logic w_empty;
  logic w_full;
  logic w_hs;
  logic w_pop;
  logic w_wr;
  logic w_drop;

  assign w_empty = (r_level == '0);
  assign w_full  = (r_level == LVL_FULL);
  assign w_hs    = r_tx_valid && tx_ready;
  // Pop either from IDLE or on the closing handshake so frames run back to back.
  assign w_pop   = !w_empty && ((r_state == ST_IDLE) || ((r_state == ST_CSUM) && w_hs));
  assign w_wr    = kalman_valid && (!w_full || w_pop);
  assign w_drop  = kalman_valid && w_full && !w_pop;

  // Storage has no reset so it maps onto block RAM; a full FIFO reads the old
  // word at rd_ptr while the same slot is overwritten.
  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wr_ptr] <= kalman_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_drop_cnt <= '0;
    end else begin
      if (w_wr)  r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_ONE;
      case ({w_wr, w_pop})
        2'b10:   r_level <= r_level + LVL_ONE;
        2'b01:   r_level <= r_level - LVL_ONE;
        default: r_level <= r_level;
      endcase
      if (w_drop && (r_drop_cnt != 16'hFFFF)) begin
        r_drop_cnt <= r_drop_cnt + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_hold     <= '0;
      r_seq      <= 8'h00;
      r_tx_data  <= 8'h00;
      r_tx_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_pop) begin
            r_hold     <= r_mem[r_rd_ptr];
            r_tx_data  <= SYNC_BYTE;
            r_tx_valid <= 1'b1;
            r_state    <= ST_SYNC;
          end
        end
        ST_SYNC: begin
          if (w_hs) begin
            r_tx_data <= r_seq;
            r_state   <= ST_SEQ;
          end
        end
        ST_SEQ: begin
          if (w_hs) begin
            r_tx_data <= r_hold[15:8];
            r_state   <= ST_HI;
          end
        end
        ST_HI: begin
          if (w_hs) begin
            r_tx_data <= r_hold[7:0];
            r_state   <= ST_LO;
          end
        end
        ST_LO: begin
          if (w_hs) begin
            r_tx_data <= r_seq ^ r_hold[15:8] ^ r_hold[7:0];
            r_state   <= ST_CSUM;
          end
        end
        ST_CSUM: begin
          if (w_hs) begin
            r_seq <= r_seq + 8'd1;
            if (w_pop) begin
              r_hold    <= r_mem[r_rd_ptr];
              r_tx_data <= SYNC_BYTE;
              r_state   <= ST_SYNC;
            end else begin
              r_tx_data  <= 8'h00;
              r_tx_valid <= 1'b0;
              r_state    <= ST_IDLE;
            end
          end
        end
        default: begin
          r_tx_valid <= 1'b0;
          r_state    <= ST_IDLE;
        end
      endcase
    end
  end

  assign tx_data    = r_tx_data;
  assign tx_valid   = r_tx_valid;
  assign fifo_level = r_level;
  assign drop_cnt   = r_drop_cnt;
  assign busy       = (r_state != ST_IDLE);

endmodule

// File: tb/tb_fusion_out_tx.sv
// Scoreboard bench for fusion_out_tx: each accepted sample queues its 5 frame bytes,
// and a negedge monitor compares every handshaken byte against the queue.
module tb_fusion_out_tx;

  logic        clk;
  logic        rst_n;
  logic [15:0] kalman_data;
  logic        kalman_valid;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [3:0]  fifo_level;
  logic [15:0] drop_cnt;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int frames = 0;
  logic [7:0] exp_q[$];
  logic [7:0] model_seq;

  logic       prev_stall;
  logic [7:0] prev_data;

  fusion_out_tx #(.FIFO_DEPTH(8), .SYNC_BYTE(8'hA5), .DATA_WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .kalman_data(kalman_data), .kalman_valid(kalman_valid),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .fifo_level(fifo_level), .drop_cnt(drop_cnt), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_frame(input logic [15:0] d);
    exp_q.push_back(8'hA5);
    exp_q.push_back(model_seq);
    exp_q.push_back(d[15:8]);
    exp_q.push_back(d[7:0]);
    exp_q.push_back(model_seq ^ d[15:8] ^ d[7:0]);
    model_seq = model_seq + 8'd1;
  endtask

  task automatic strobe(input logic [15:0] d, input bit accept);
    kalman_data  = d;
    kalman_valid = 1'b1;
    if (accept) push_frame(d);
    tick();
    kalman_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    exp_q.delete();
    model_seq = 8'h00;
  endtask

  task automatic wait_drain(input string tag);
    bit done = 0;
    for (int i = 0; i < 3000; i++) begin
      if (!busy && fifo_level == 0 && !tx_valid) begin
        done = 1;
        break;
      end
      tick();
    end
    check({tag, "_drain"}, 32'(done), 32'd1);
    check({tag, "_sb_empty"}, exp_q.size(), 32'd0);
  endtask

  // Byte monitor plus stall-stability check, sampled between rising edges.
  always @(negedge clk) begin
    logic [7:0] e;
    if (rst_n && prev_stall) begin
      check("stall_valid", 32'(tx_valid), 32'd1);
      check("stall_data", 32'(tx_data), 32'(prev_data));
    end
    if (rst_n && tx_valid && tx_ready) begin
      if (exp_q.size() == 0) begin
        check("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
      end else begin
        e = exp_q.pop_front();
        check("tx_byte", 32'(tx_data), 32'(e));
        if (exp_q.size() % 5 == 0) begin
          frames++;
          $display("frame %0d done: csum %02h at %0t", frames, tx_data, $time);
        end
      end
    end
    prev_stall = rst_n && tx_valid && !tx_ready;
    prev_data  = tx_data;
  end

  initial begin
    int vcnt;
    prev_stall   = 1'b0;
    prev_data    = 8'h00;
    model_seq    = 8'h00;
    rst_n        = 1'b0;
    kalman_data  = 16'h0000;
    kalman_valid = 1'b0;
    tx_ready     = 1'b0;
    tick();
    tick();
    check("rst_valid", 32'(tx_valid), 32'd0);
    check("rst_data", 32'(tx_data), 32'h00);
    check("rst_level", 32'(fifo_level), 32'd0);
    check("rst_drop", 32'(drop_cnt), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    tick();

    // Single sample latency
    do_reset();
    tx_ready = 1'b1;
    strobe(16'h1234, 1);
    check("single_n1_valid", 32'(tx_valid), 32'd0);
    tick();
    check("single_n2_valid", 32'(tx_valid), 32'd1);
    check("single_n2_sync", 32'(tx_data), 32'hA5);
    repeat (5) tick();
    check("single_n7_valid", 32'(tx_valid), 32'd0);
    check("single_n7_busy", 32'(busy), 32'd0);
    check("single_sb", exp_q.size(), 32'd0);

    // Back-to-back frames without bubbles
    do_reset();
    tx_ready = 1'b1;
    strobe(16'h0001, 1);
    strobe(16'h0002, 1);
    check("b2b_first_valid", 32'(tx_valid), 32'd1);
    check("b2b_first_sync", 32'(tx_data), 32'hA5);
    strobe(16'h0003, 1);
    vcnt = 1;
    for (int i = 0; i < 20; i++) begin
      if (!tx_valid) break;
      vcnt++;
      tick();
    end
    check("b2b_valid_run", 32'(vcnt), 32'd15);
    wait_drain("b2b");

    // Backpressure while DATA_HI is presented
    do_reset();
    tx_ready = 1'b1;
    strobe(16'h1234, 1);
    repeat (3) tick();
    tx_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("bp_valid", 32'(tx_valid), 32'd1);
      check("bp_hi", 32'(tx_data), 32'h12);
      tick();
    end
    tx_ready = 1'b1;
    wait_drain("bp");

    // Overflow: 9 held, 10th dropped
    do_reset();
    tx_ready = 1'b0;
    for (int i = 0; i < 10; i++) strobe(16'h0100 + 16'(i), i < 9);
    check("ovf_level", 32'(fifo_level), 32'd8);
    check("ovf_drop", 32'(drop_cnt), 32'd1);
    tx_ready = 1'b1;
    wait_drain("ovf");
    check("ovf_drop_kept", 32'(drop_cnt), 32'd1);

    // Sequence wrap over 257 frames
    do_reset();
    tx_ready = 1'b1;
    for (int i = 0; i < 257; i++) begin
      strobe(16'h00FF, 1);
      repeat (4) tick();
    end
    wait_drain("wrap");
    check("wrap_seq", 32'(model_seq), 32'h01);

    // Reset in the middle of a frame
    do_reset();
    tx_ready = 1'b1;
    strobe(16'hBEEF, 1);
    strobe(16'hCAFE, 1);
    strobe(16'hF00D, 1);
    tick();
    check("mid_hi", 32'(tx_data), 32'hBE);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    exp_q.delete();
    model_seq = 8'h00;
    check("mid_rst_valid", 32'(tx_valid), 32'd0);
    check("mid_rst_level", 32'(fifo_level), 32'd0);
    check("mid_rst_drop", 32'(drop_cnt), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    strobe(16'h5A3C, 1);
    wait_drain("mid_after");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
